// File: rtl/gpio_apb_bank.sv
`default_nettype none
// ============================================================================
// Module      : gpio_apb_bank
// Description : APB slave register bank for one GPIO port of the SPI GPIO
//               expander. Holds the direction and output registers, the
//               two-flop input synchronizer, and the edge-interrupt logic.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_apb_bank #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 3,
  parameter int WAIT_STATES = 0
) (
  input  logic                  sclk,
  input  logic                  resetn,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  input  logic [DATA_WIDTH-1:0] gpio_in,
  output logic [DATA_WIDTH-1:0] gpio_out,
  output logic [DATA_WIDTH-1:0] gpio_oe,
  output logic                  irq
);

  localparam logic [2:0]            c_wait     = 3'(WAIT_STATES);
  localparam logic [ADDR_WIDTH-1:0] c_addr_out  = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] c_addr_dir  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] c_addr_in   = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] c_addr_ien  = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] c_addr_edge = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] c_addr_stat = ADDR_WIDTH'(5);
  localparam logic [ADDR_WIDTH-1:0] c_addr_set  = ADDR_WIDTH'(6);
  localparam logic [ADDR_WIDTH-1:0] c_addr_clr  = ADDR_WIDTH'(7);

  logic [2:0]            r_wait_cnt;
  logic [DATA_WIDTH-1:0] r_out;
  logic [DATA_WIDTH-1:0] r_dir;
  logic [DATA_WIDTH-1:0] r_ien;
  logic [DATA_WIDTH-1:0] r_edge;
  logic [DATA_WIDTH-1:0] r_stat;
  logic [DATA_WIDTH-1:0] r_sync1;
  logic [DATA_WIDTH-1:0] r_in;
  logic [DATA_WIDTH-1:0] r_prev;
  logic                  r_irq;

  logic                  w_access;
  logic                  w_commit;
  logic [DATA_WIDTH-1:0] w_event;
  logic [DATA_WIDTH-1:0] w_stat_clr;
  logic [DATA_WIDTH-1:0] w_rd_data;

  assign w_access = psel & penable;
  assign pready   = w_access & (r_wait_cnt == c_wait);
  // A write takes effect only on the edge that completes the transfer
  assign w_commit = pready & pwrite;

  // Wait-state counter: restarts whenever the access phase is left
  always_ff @(posedge sclk or negedge resetn) begin
    if (!resetn) begin
      r_wait_cnt <= 3'd0;
    end else if (!w_access) begin
      r_wait_cnt <= 3'd0;
    end else if (r_wait_cnt != c_wait) begin
      r_wait_cnt <= r_wait_cnt + 3'd1;
    end
  end

  // Writable control registers; OUT_SET/OUT_CLR modify OUT bitwise
  always_ff @(posedge sclk or negedge resetn) begin
    if (!resetn) begin
      r_out  <= '0;
      r_dir  <= '0;
      r_ien  <= '0;
      r_edge <= '0;
    end else if (w_commit) begin
      if (paddr == c_addr_out)  r_out  <= pwdata;
      if (paddr == c_addr_set)  r_out  <= r_out | pwdata;
      if (paddr == c_addr_clr)  r_out  <= r_out & ~pwdata;
      if (paddr == c_addr_dir)  r_dir  <= pwdata;
      if (paddr == c_addr_ien)  r_ien  <= pwdata;
      if (paddr == c_addr_edge) r_edge <= pwdata;
    end
  end

  // Pad synchronizer (two flops) plus previous-value flop for edge detection
  always_ff @(posedge sclk or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= '0;
      r_in    <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= gpio_in;
      r_in    <= r_sync1;
      r_prev  <= r_in;
    end
  end

  // EDGE selects rising (1) or falling (0) per bit; IEN masks new events
  assign w_event    = r_ien & ((r_in & ~r_prev & r_edge) | (~r_in & r_prev & ~r_edge));
  assign w_stat_clr = (w_commit && (paddr == c_addr_stat)) ? pwdata : '0;

  // Sticky status: clear is applied first so a coincident event survives
  always_ff @(posedge sclk or negedge resetn) begin
    if (!resetn) begin
      r_stat <= '0;
      r_irq  <= 1'b0;
    end else begin
      r_stat <= (r_stat & ~w_stat_clr) | w_event;
      r_irq  <= |r_stat;
    end
  end

  // Read mux; write-only and unmapped addresses return zero
  always_comb begin
    w_rd_data = '0;
    case (paddr)
      c_addr_out:  w_rd_data = r_out;
      c_addr_dir:  w_rd_data = r_dir;
      c_addr_in:   w_rd_data = r_in;
      c_addr_ien:  w_rd_data = r_ien;
      c_addr_edge: w_rd_data = r_edge;
      c_addr_stat: w_rd_data = r_stat;
      default:     w_rd_data = '0;
    endcase
  end

  // Read data is presented on the completing cycle of a read, zero otherwise
  assign prdata   = (pready & ~pwrite) ? w_rd_data : '0;
  assign gpio_out = r_out;
  assign gpio_oe  = r_dir;
  assign irq      = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_gpio_apb_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpio_apb_bank
// Description : Self-checking bench for gpio_apb_bank (three wait states).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_apb_bank;

  localparam int WS = 3;

  typedef struct {
    bit         wr;
    logic [2:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  logic       sclk = 1'b0;
  logic       resetn = 1'b0;
  logic       psel = 1'b0;
  logic       penable = 1'b0;
  logic       pwrite = 1'b0;
  logic [2:0] paddr = 3'd0;
  logic [7:0] pwdata = 8'h00;
  logic [7:0] prdata;
  logic       pready;
  logic [7:0] gpio_in = 8'h00;
  logic [7:0] gpio_out;
  logic [7:0] gpio_oe;
  logic       irq;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [7:0] sb_q[$];
  vec_t tbl[$];

  gpio_apb_bank #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (3),
    .WAIT_STATES(WS)
  ) dut (
    .sclk    (sclk),
    .resetn  (resetn),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .gpio_in (gpio_in),
    .gpio_out(gpio_out),
    .gpio_oe (gpio_oe),
    .irq     (irq)
  );

  always #5 sclk = ~sclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One APB transfer; read expectations go through the scoreboard queue
  task automatic apb(input bit wr, input logic [2:0] a, input logic [7:0] d, input logic [7:0] exp);
    int cyc;
    bit done;
    logic [7:0] e;
    @(posedge sclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    if (!wr) sb_q.push_back(exp);
    @(posedge sclk); #1;
    penable = 1'b1;
    cyc = 0;
    done = 1'b0;
    while (!done && cyc < 20) begin
      @(negedge sclk);
      cyc++;
      if (pready) begin
        done = 1'b1;
        if (!wr) begin
          if (sb_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL scoreboard_empty: got read at addr %0d, expected a queued value", a);
          end else begin
            e = sb_q.pop_front();
            check($sformatf("prdata_addr%0d", a), {24'h0, prdata}, {24'h0, e});
          end
        end
      end
    end
    if (!done) begin
      n_cmp++; n_fail++;
      $display("FAIL pready_timeout: got no pready in 20 cycles, expected pready");
    end else begin
      check("wait_cycles", cyc, WS + 1);
    end
    @(posedge sclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    // Reset release and reset state
    repeat (3) @(posedge sclk);
    #1 resetn = 1'b1;
    @(negedge sclk);
    check("rst_gpio_oe", gpio_oe, 8'h00);
    check("rst_gpio_out", gpio_out, 8'h00);
    check("rst_irq", irq, 1'b0);
    check("rst_pready", pready, 1'b0);
    check("rst_prdata", prdata, 8'h00);

    // Register map table: reset reads, then DIR/OUT/OUT_SET/OUT_CLR
    for (int i = 0; i < 8; i++) tbl.push_back('{1'b0, 3'(i), 8'h00, 8'h00});
    tbl.push_back('{1'b1, 3'd1, 8'hF0, 8'h00});
    tbl.push_back('{1'b1, 3'd0, 8'hA5, 8'h00});
    tbl.push_back('{1'b0, 3'd0, 8'h00, 8'hA5});
    tbl.push_back('{1'b1, 3'd6, 8'h0A, 8'h00});
    tbl.push_back('{1'b0, 3'd0, 8'h00, 8'hAF});
    tbl.push_back('{1'b1, 3'd7, 8'h81, 8'h00});
    tbl.push_back('{1'b0, 3'd0, 8'h00, 8'h2E});
    tbl.push_back('{1'b0, 3'd6, 8'h00, 8'h00});
    tbl.push_back('{1'b0, 3'd7, 8'h00, 8'h00});
    tbl.push_back('{1'b0, 3'd1, 8'h00, 8'hF0});
    tbl.push_back('{1'b1, 3'd3, 8'h03, 8'h00});
    tbl.push_back('{1'b1, 3'd4, 8'h01, 8'h00});
    tbl.push_back('{1'b0, 3'd3, 8'h00, 8'h03});
    tbl.push_back('{1'b0, 3'd4, 8'h00, 8'h01});
    for (int i = 0; i < tbl.size(); i++) begin
      apb(tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].exp);
      if (i == 7) gpio_in = 8'h02;   // pin1 high while IEN is still 0
    end
    check("gpio_oe_dir", gpio_oe, 8'hF0);
    check("gpio_out_out", gpio_out, 8'h2E);
    check("irq_masked", irq, 1'b0);

    // Edge interrupts: pin0 rises, pin1 falls, pin2 rises (not enabled)
    @(posedge sclk); #1;
    gpio_in = 8'h05;
    for (int k = 1; k <= 5; k++) begin
      @(negedge sclk);
      check($sformatf("irq_latency_c%0d", k), irq, (k == 5) ? 1'b1 : 1'b0);
    end
    apb(1'b0, 3'd5, 8'h00, 8'h03);
    apb(1'b0, 3'd2, 8'h00, 8'h05);
    apb(1'b1, 3'd5, 8'h01, 8'h00);
    apb(1'b0, 3'd5, 8'h00, 8'h02);
    check("irq_still_set", irq, 1'b1);
    apb(1'b1, 3'd5, 8'h02, 8'h00);
    apb(1'b0, 3'd5, 8'h00, 8'h00);
    check("irq_cleared", irq, 1'b0);

    // Wait states: IN read, then a hand-driven OUT write
    gpio_in = 8'h5C;
    repeat (3) @(posedge sclk);
    apb(1'b0, 3'd2, 8'h00, 8'h5C);
    @(posedge sclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 3'd0; pwdata = 8'h11;
    @(posedge sclk); #1;
    penable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge sclk);
      check($sformatf("ws_pready_c%0d", k), pready, (k == 3) ? 1'b1 : 1'b0);
      check($sformatf("ws_out_hold_c%0d", k), gpio_out, 8'h2E);
    end
    @(posedge sclk); #1;
    check("ws_out_commit", gpio_out, 8'h11);
    psel = 1'b0; penable = 1'b0;
    #1 check("pready_drop", pready, 1'b0);

    // W1C race: set STAT[0] first, then clear it as a new rising event lands
    gpio_in = 8'h5D;
    repeat (5) @(posedge sclk);
    gpio_in = 8'h5C;
    repeat (5) @(posedge sclk);
    apb(1'b0, 3'd5, 8'h00, 8'h01);
    @(posedge sclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 3'd5; pwdata = 8'h01;
    @(posedge sclk); #1;
    penable = 1'b1;
    @(posedge sclk); #1;
    gpio_in = 8'h5D;                 // reaches STAT on the commit edge
    @(posedge sclk);
    @(posedge sclk);
    @(negedge sclk);
    check("race_pready", pready, 1'b1);
    @(posedge sclk); #1;
    psel = 1'b0; penable = 1'b0;
    apb(1'b0, 3'd5, 8'h00, 8'h01);
    apb(1'b1, 3'd5, 8'h01, 8'h00);
    apb(1'b0, 3'd5, 8'h00, 8'h00);

    // Reset during the access phase of a DIR write
    @(posedge sclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 3'd1; pwdata = 8'hFF;
    @(posedge sclk); #1;
    penable = 1'b1;
    @(negedge sclk);
    resetn = 1'b0;
    #1;
    check("mid_rst_gpio_oe", gpio_oe, 8'h00);
    check("mid_rst_gpio_out", gpio_out, 8'h00);
    psel = 1'b0; penable = 1'b0;
    @(posedge sclk); #1;
    resetn = 1'b1;
    apb(1'b0, 3'd1, 8'h00, 8'h00);
    check("post_rst_gpio_oe", gpio_oe, 8'h00);
    apb(1'b1, 3'd0, 8'h33, 8'h00);
    apb(1'b0, 3'd0, 8'h00, 8'h33);
    check("post_rst_gpio_out", gpio_out, 8'h33);
    check("sb_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
